dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache placed between the CPU memory stage and the backing data memory. Read hits return data in the same cycle. Read misses and all writes stall the CPU while a single-word transaction runs on a valid/ready memory port. The backing memory holds the only authoritative copy; the cache never holds dirty data.

## Interface
Parameters:
- ADDRESS_WIDTH, 32: CPU and memory address width.
- DATA_WIDTH, 32: word width.
- SET_WIDTH, 6: index bits, giving 64 one-word lines. Tag is ADDRESS_WIDTH-SET_WIDTH-2 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  clears all valid bits at the next edge; ignored unless state is IDLE.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request; has priority over cpu_re.
- cpu_byte  in  1  byte access (1) or word access (0).
- cpu_addr  in  ADDRESS_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data; a byte store uses [7:0].
- cpu_rdata  out  DATA_WIDTH  load data; a byte load is zero-extended.
- cpu_stall  out  1  holds the CPU pipeline.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write.
- mem_byte  out  1  memory byte write.
- mem_addr  out  ADDRESS_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read word, valid while mem_ready=1.
- mem_ready  in  1  memory completes the current request.

## Operation
- **Address split:** tag = addr[31:8], index = addr[7:2], offset = addr[1:0]. Hit = valid[index] & (tag[index] == addr tag).
- **Byte order:** big-endian lanes. Offset 0 maps to word[31:24] and offset 3 maps to word[7:0].
- **FSM states:** IDLE, FILL, WRITE.
- **IDLE:**
  - cpu_we=1: latch addr, wdata and byte. Go to WRITE.
  - cpu_re=1 on a miss: latch addr. Go to FILL.
  - cpu_re=1 on a hit: stay in IDLE.
  - flush=1 with no pending access: clear every valid bit.
- **FILL:**
  - mem_req=1, mem_we=0, mem_addr = {latched addr[31:2], 2'b00}.
  - On mem_ready=1: write mem_rdata into the line, set tag and valid. Go to IDLE.
- **WRITE:**
  - mem_req=1, mem_we=1, mem_byte = latched byte, mem_addr = latched addr (unaligned for a byte store), mem_wdata = latched wdata.
  - On mem_ready=1: if the latched address hits, merge the data into the line. A word store replaces the whole line; a byte store replaces only the offset lane. A miss does not allocate. Go to IDLE.
- **cpu_stall (combinational):**
  - IDLE: 1 when cpu_we=1, or when cpu_re=1 and the access misses. Otherwise 0.
  - FILL: 1.
  - WRITE: equals ~mem_ready.
- **cpu_rdata:** hit word or selected byte lane when cpu_re=1, the access hits and the state is IDLE. Otherwise 0.
- **Memory port outputs:** all mem_* outputs are registered. Outside FILL and WRITE, mem_req=0 and mem_we=0.

## Timing
- **Reset values:**
  - All valid bits cleared; state IDLE.
  - mem_req, mem_we and mem_byte = 0; mem_addr and mem_wdata = 0.
  - While rst_n=0, cpu_stall=0 and cpu_rdata=0.
- **Read hit:** 0-cycle latency, no stall.
- **Read miss:** stall in the detect cycle. FILL starts at the next edge. The line is written at the edge where mem_ready=1. The following IDLE cycle hits with stall=0. Minimum penalty is 2 cycles plus memory wait cycles.
- **Store:**
  - Stall in the IDLE cycle; WRITE at the next edge.
  - Stall drops combinationally in the cycle mem_ready=1. The CPU advances at that edge, so the store is not reissued.
  - Minimum: 1 stall cycle plus 1 WRITE cycle.
- **Handshake:** mem_addr, mem_we, mem_byte and mem_wdata stay stable while mem_req=1 and mem_ready=0. mem_ready outside FILL or WRITE is ignored.
- **Simultaneous events:** cpu_we and cpu_re together is treated as a store. flush together with a pending access is ignored.
- **Reset mid-transaction:** mem_req drops asynchronously and the transaction is abandoned. No line is updated.
- **Index wrap:** addresses 0x100 apart share a set. The fill overwrites the old line.

## Test plan
- **Reset then cold read:** reset, then cpu_re at 0x10000 with memory word 0xDEADBEEF → stall for 2 cycles (mem_ready immediate). mem_addr=0x10000. Then cpu_rdata=0xDEADBEEF with stall=0.
- **Hit and byte loads:** repeat the 0x10000 read → no stall, no mem_req. Byte load at 0x10001 → 0x000000AD. Byte load at 0x10003 → 0x000000EF.
- **Byte store hit with delayed memory:** mem_ready delayed 3 cycles. Byte store 0x55 to 0x10002 → mem_byte=1, mem_addr=0x10002, stall for 4 cycles. Then word read at 0x10000 hits with 0xDEAD55EF.
- **Store miss, no allocate:** word store to 0x10400 (line not cached) → a single memory write. A following read of 0x10400 misses and issues FILL.
- **Conflict:** read 0x10000, then 0x10100 (same index, new tag) → second read misses and refills. Third read of 0x10000 misses again.
- **Flush and reset:** flush in IDLE → next read of 0x10000 misses. Drop rst_n during FILL → mem_req=0 immediately; after release the same read misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines,
// sitting between the CPU memory stage and a single-word valid/ready memory port.
module dcache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic                     cpu_byte,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int LINES     = 1 << SET_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    WRITE = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [TAG_WIDTH-1:0]     tag_q  [LINES];
  logic [DATA_WIDTH-1:0]    data_q [LINES];

  // The memory-port registers double as the latched request during FILL/WRITE.
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic                     mem_byte_q, mem_byte_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  logic                     line_we_s;
  logic [DATA_WIDTH-1:0]    line_wdata_s;
  logic [SET_WIDTH-1:0]     req_index_s, lat_index_s;
  logic [TAG_WIDTH-1:0]     req_tag_s, lat_tag_s;
  logic                     req_hit_s, lat_hit_s;
  logic                     cpu_stall_s;
  logic [DATA_WIDTH-1:0]    cpu_rdata_s;

  // Big-endian lanes: offset 0 is the most significant byte.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {~offset, 3'b000};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_data(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0]            offset,
                                                      input logic                  is_byte);
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] result;
    shifted = word >> lane_shift(offset);
    if (is_byte) begin
      result = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
    end else begin
      result = word;
    end
    return result;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_data,
                                                        input logic [1:0]            offset,
                                                        input logic                  is_byte);
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] result;
    lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << lane_shift(offset);
    lane_data = {{(DATA_WIDTH-8){1'b0}}, new_data[7:0]} << lane_shift(offset);
    if (is_byte) begin
      result = (old_word & ~lane_mask) | lane_data;
    end else begin
      result = new_data;
    end
    return result;
  endfunction

  assign req_index_s = cpu_addr[SET_WIDTH+1:2];
  assign req_tag_s   = cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign req_hit_s   = valid_q[req_index_s] && (tag_q[req_index_s] == req_tag_s);

  assign lat_index_s = mem_addr_q[SET_WIDTH+1:2];
  assign lat_tag_s   = mem_addr_q[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign lat_hit_s   = valid_q[lat_index_s] && (tag_q[lat_index_s] == lat_tag_s);

  // Next-state, stall/load data and memory-port next values
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_byte_d   = mem_byte_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    line_we_s    = 1'b0;
    line_wdata_s = {DATA_WIDTH{1'b0}};
    cpu_stall_s  = 1'b0;
    cpu_rdata_s  = {DATA_WIDTH{1'b0}};

    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          state_d     = WRITE;
          cpu_stall_s = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_byte_d  = cpu_byte;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end else if (cpu_re) begin
          if (req_hit_s) begin
            cpu_rdata_s = load_data(data_q[req_index_s], cpu_addr[1:0], cpu_byte);
          end else begin
            state_d     = FILL;
            cpu_stall_s = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_byte_d  = 1'b0;
            mem_addr_d  = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
          end
        end else if (flush) begin
          valid_d = {LINES{1'b0}};
        end else begin
          valid_d = valid_q;
        end
      end

      FILL: begin
        cpu_stall_s = 1'b1;
        if (mem_ready) begin
          state_d              = IDLE;
          mem_req_d            = 1'b0;
          mem_we_d             = 1'b0;
          line_we_s            = 1'b1;
          line_wdata_s         = mem_rdata;
          valid_d[lat_index_s] = 1'b1;
        end else begin
          state_d = FILL;
        end
      end

      WRITE: begin
        cpu_stall_s = ~mem_ready;
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_byte_d = 1'b0;
          // No allocation on a store miss; only a resident line is updated.
          if (lat_hit_s) begin
            line_we_s    = 1'b1;
            line_wdata_s = store_merge(data_q[lat_index_s], mem_wdata_q,
                                       mem_addr_q[1:0], mem_byte_q);
          end else begin
            line_we_s = 1'b0;
          end
        end else begin
          state_d = WRITE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State, valid bits and registered memory-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= {LINES{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Line storage; contents only matter under a set valid bit, so no reset
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_q[lat_index_s]  <= lat_tag_s;
      data_q[lat_index_s] <= line_wdata_s;
    end
  end

  assign cpu_stall = rst_n & cpu_stall_s;
  assign cpu_rdata = rst_n ? cpu_rdata_s : {DATA_WIDTH{1'b0}};
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
